// File: rtl/divider_pkg.sv
// Shared width helpers and default geometry for the power divider chain.
package divider_pkg;

   localparam int unsigned DefaultRadix  = 5;
   localparam int unsigned DefaultStages = 8;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(value)) begin
         r++;
      end
      return r;
   endfunction

   // Counter width; never below one bit.
   function automatic int unsigned cw(input int unsigned radix);
      return (clog2(radix) < 1) ? 1 : clog2(radix);
   endfunction

   // Power select width: must encode 0..stages plus out-of-range values.
   function automatic int unsigned pw(input int unsigned stages);
      return (clog2(stages + 1) < 1) ? 1 : clog2(stages + 1);
   endfunction

endpackage

// File: rtl/radix_counter_stage.sv
// One modulo-RADIX stage of the divider chain; carry is combinational.
module radix_counter_stage
   import divider_pkg::*;
#(
   parameter int unsigned RADIX = DefaultRadix,
   localparam int unsigned CW   = cw(RADIX)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clear_i,
   input  logic          inc_i,
   output logic [CW-1:0] cnt_o,
   output logic          carry_o
);

   if (RADIX < 2) begin : g_bad_radix
      $error("radix_counter_stage: RADIX must be >= 2");
   end

   localparam logic [CW-1:0] CntMax = CW'(RADIX - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign carry_o = inc_i & (cnt_q == CntMax);
   assign cnt_o   = cnt_q;

   // Clear outranks increment so a power switch restarts the period cleanly.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = carry_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/power_divider_chain.sv
// Cascade of RADIX counters emitting a tick every RADIX^power enabled cycles.
// Optional DIVIDER_SYNC_EN adds sync_i for phase alignment of several dividers.
module power_divider_chain
   import divider_pkg::*;
#(
   parameter int unsigned RADIX  = DefaultRadix,
   parameter int unsigned STAGES = DefaultStages,
   localparam int unsigned CW    = cw(RADIX),
   localparam int unsigned PW    = pw(STAGES)
) (
   input  logic          clk_i,
   input  logic          rst_i,
`ifdef DIVIDER_SYNC_EN
   input  logic          sync_i,
`endif
   input  logic          enable_i,
   input  logic [PW-1:0] power_i,
   output logic          tick_o,
   output logic          wave_o,
   output logic          range_err_o
);

   if (RADIX < 2 || STAGES < 1) begin : g_bad_geometry
      $error("power_divider_chain: need RADIX >= 2 and STAGES >= 1");
   end

   localparam int unsigned  SelW     = 2 ** PW;
   localparam logic [PW-1:0] MaxPower = PW'(STAGES);

   logic sync;
`ifdef DIVIDER_SYNC_EN
   assign sync = sync_i;
`else
   assign sync = 1'b0;
`endif

   logic [PW-1:0]             power_q, power_d;
   logic                      range_err_q, range_err_d;
   logic                      tick_q, wave_q;
   logic                      sel, load, clear;
   logic [SelW-1:0]           sel_vec;
   logic [STAGES-1:0][CW-1:0] cnt;
   logic                      unused_cnt;

   assign sel_vec[0] = enable_i;
   if (SelW > STAGES + 1) begin : g_sel_pad
      assign sel_vec[SelW-1:STAGES+1] = '0;
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic inc_k, carry_k;
      if (k == 0) begin : g_first
         assign inc_k = enable_i;
      end else begin : g_next
         assign inc_k = g_stage[k-1].carry_k;
      end
      assign sel_vec[k+1] = carry_k;

      radix_counter_stage #(
         .RADIX(RADIX)
      ) u_stage (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .clear_i(clear),
         .inc_i  (inc_k),
         .cnt_o  (cnt[k]),
         .carry_o(carry_k)
      );
   end

   // Stage counts are only observed through the carry chain.
   assign unused_cnt = ^cnt;

   // Power is only accepted at a period boundary or while out of range.
   always_comb begin
      sel         = sel_vec[power_q] & ~range_err_q & ~sync;
      load        = rst_i | sync | sel | range_err_q;
      power_d     = load ? power_i : power_q;
      clear       = rst_i | sync | range_err_q | (power_d != power_q);
      range_err_d = (power_d > MaxPower);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         power_q     <= power_i;
         range_err_q <= (power_i > MaxPower);
         tick_q      <= 1'b0;
         wave_q      <= 1'b0;
      end else begin
         power_q     <= power_d;
         range_err_q <= range_err_d;
         tick_q      <= sel;
         wave_q      <= sync ? 1'b0 : (wave_q ^ sel);
      end
   end

   assign tick_o      = tick_q;
   assign wave_o      = wave_q;
   assign range_err_o = range_err_q;

endmodule
